// File: rtl/clint_rtc_gen_if.sv
// Config port of the rtc generator: one valid/ready handshake carrying a new
// accumulator increment.
interface clint_rtc_gen_if #(
    parameter int unsigned W = 32
);
    logic         cfg_valid_i;
    logic [W-1:0] cfg_inc_i;
    logic         cfg_ready_o;

    modport master (
        output cfg_valid_i,
        output cfg_inc_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i,
        input  cfg_inc_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/clint_rtc_gen.sv
// Phase-accumulator rtc generator for the CLINT rtc_i input. New increments
// are held in a shadow register and switched in only on an rtc rising edge.
module clint_rtc_gen #(
    parameter int unsigned          ACC_WIDTH   = 32,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = {1'b1, {(ACC_WIDTH-1){1'b0}}}
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 en_i,
    input  logic                 halt_i,
    clint_rtc_gen_if.slave       cfg,
    output logic                 rtc_o,
    output logic                 tick_o,
    output logic [ACC_WIDTH-1:0] inc_o
);

    localparam logic [ACC_WIDTH-1:0] HALF_INC = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] ZERO_INC = {ACC_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    // Increments above half scale would let an rtc level vanish between samples.
    function automatic logic [ACC_WIDTH-1:0] clamp_inc(input logic [ACC_WIDTH-1:0] req);
        logic [ACC_WIDTH-1:0] res;
        if (req > HALF_INC) begin
            res = HALF_INC;
        end else begin
            res = req;
        end
        return res;
    endfunction

    logic [ACC_WIDTH-1:0] acc_r;
    logic [ACC_WIDTH-1:0] inc_act_r;
    logic [ACC_WIDTH-1:0] shadow_r;
    state_t               state_r;
    logic                 tick_r;
    logic                 ready_r;

    logic [ACC_WIDTH-1:0] acc_nx_s;
    logic                 adv_s;
    logic                 rise_s;
    logic [ACC_WIDTH-1:0] inc_act_nx_s;
    logic [ACC_WIDTH-1:0] shadow_nx_s;
    state_t               state_nx_s;

    assign adv_s    = en_i & ~halt_i;
    assign acc_nx_s = acc_r + inc_act_r;
    assign rise_s   = adv_s & ~acc_r[ACC_WIDTH-1] & acc_nx_s[ACC_WIDTH-1];

    // Config FSM: accept into the shadow, then apply at a safe point.
    always_comb begin
        state_nx_s   = state_r;
        shadow_nx_s  = shadow_r;
        inc_act_nx_s = inc_act_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg.cfg_valid_i) begin
                    shadow_nx_s = clamp_inc(cfg.cfg_inc_i);
                    state_nx_s  = ST_PENDING;
                end else begin
                    state_nx_s  = ST_IDLE;
                end
            end
            ST_PENDING: begin
                // With no edge possible (disabled or frozen rtc) waiting would deadlock.
                if (halt_i) begin
                    state_nx_s = ST_PENDING;
                end else if (rise_s || !en_i || (inc_act_r == ZERO_INC)) begin
                    inc_act_nx_s = shadow_r;
                    state_nx_s   = ST_IDLE;
                end else begin
                    state_nx_s = ST_PENDING;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, accumulator and registered outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            acc_r     <= ZERO_INC;
            inc_act_r <= DEFAULT_INC;
            shadow_r  <= ZERO_INC;
            state_r   <= ST_IDLE;
            tick_r    <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            if (adv_s) begin
                acc_r <= acc_nx_s;
            end else begin
                acc_r <= acc_r;
            end
            inc_act_r <= inc_act_nx_s;
            shadow_r  <= shadow_nx_s;
            state_r   <= state_nx_s;
            tick_r    <= rise_s;
            ready_r   <= (state_nx_s == ST_IDLE);
        end
    end

    assign rtc_o           = acc_r[ACC_WIDTH-1];
    assign tick_o          = tick_r;
    assign inc_o           = inc_act_r;
    assign cfg.cfg_ready_o = ready_r;

endmodule

// File: tb/tb_clint_rtc_gen.sv
// Directed bench for clint_rtc_gen (W = 32): rate changes, clamp, zero rate,
// halt, disabled apply, same-cycle acceptance and reset while pending.
module tb_clint_rtc_gen;

    logic        aclk;
    logic        areset;
    logic        en_i;
    logic        halt_i;
    logic        rtc_o;
    logic        tick_o;
    logic [31:0] inc_o;
    int          checks;
    int          errors;

    clint_rtc_gen_if #(.W(32)) cfg ();

    clint_rtc_gen #(.ACC_WIDTH(32)) dut (
        .aclk   (aclk),
        .areset (areset),
        .en_i   (en_i),
        .halt_i (halt_i),
        .cfg    (cfg.slave),
        .rtc_o  (rtc_o),
        .tick_o (tick_o),
        .inc_o  (inc_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic rtc_e, input logic tick_e,
                             input logic rdy_e, input logic [31:0] inc_e);
        check({tag, ".rtc"},   {31'd0, rtc_o},           {31'd0, rtc_e});
        check({tag, ".tick"},  {31'd0, tick_o},          {31'd0, tick_e});
        check({tag, ".ready"}, {31'd0, cfg.cfg_ready_o}, {31'd0, rdy_e});
        check({tag, ".inc"},   inc_o,                    inc_e);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        areset          = 1'b1;
        en_i            = 1'b0;
        halt_i          = 1'b0;
        cfg.cfg_valid_i = 1'b0;
        cfg.cfg_inc_i   = 32'h0;
        step();
        step();
        areset = 1'b0;
        check_out("reset", 1'b0, 1'b0, 1'b1, 32'h8000_0000);

        // Default divide-by-two.
        en_i = 1'b1;
        step(); check_out("div2_a", 1'b1, 1'b1, 1'b1, 32'h8000_0000);
        step(); check_out("div2_b", 1'b0, 1'b0, 1'b1, 32'h8000_0000);
        step(); check_out("div2_c", 1'b1, 1'b1, 1'b1, 32'h8000_0000);
        step(); check_out("div2_d", 1'b0, 1'b0, 1'b1, 32'h8000_0000);

        // Accept 0x4000_0000 in a rise cycle: not applied at that rise.
        cfg.cfg_valid_i = 1'b1;
        cfg.cfg_inc_i   = 32'h4000_0000;
        step(); check_out("same_rise", 1'b1, 1'b1, 1'b0, 32'h8000_0000);
        cfg.cfg_valid_i = 1'b0;
        step(); check_out("pend_low", 1'b0, 1'b0, 1'b0, 32'h8000_0000);
        step(); check_out("apply_q", 1'b1, 1'b1, 1'b1, 32'h4000_0000);
        step(); check_out("q_a", 1'b1, 1'b0, 1'b1, 32'h4000_0000);
        step(); check_out("q_b", 1'b0, 1'b0, 1'b1, 32'h4000_0000);
        step(); check_out("q_c", 1'b0, 1'b0, 1'b1, 32'h4000_0000);
        step(); check_out("q_d", 1'b1, 1'b1, 1'b1, 32'h4000_0000);
        step(); check_out("q_e", 1'b1, 1'b0, 1'b1, 32'h4000_0000);
        step(); check_out("q_f", 1'b0, 1'b0, 1'b1, 32'h4000_0000);

        // Clamp: 0xFFFF_FFFF becomes half scale.
        cfg.cfg_valid_i = 1'b1;
        cfg.cfg_inc_i   = 32'hFFFF_FFFF;
        step(); check_out("clamp_acc", 1'b0, 1'b0, 1'b0, 32'h4000_0000);
        cfg.cfg_valid_i = 1'b0;
        step(); check_out("clamp_apply", 1'b1, 1'b1, 1'b1, 32'h8000_0000);
        step(); check_out("clamp_a", 1'b0, 1'b0, 1'b1, 32'h8000_0000);
        step(); check_out("clamp_b", 1'b1, 1'b1, 1'b1, 32'h8000_0000);

        // Zero increment freezes rtc; next write applies after one cycle.
        cfg.cfg_valid_i = 1'b1;
        cfg.cfg_inc_i   = 32'h0;
        step(); check_out("zero_acc", 1'b0, 1'b0, 1'b0, 32'h8000_0000);
        cfg.cfg_valid_i = 1'b0;
        step(); check_out("zero_apply", 1'b1, 1'b1, 1'b1, 32'h0);
        step(); check_out("frozen_a", 1'b1, 1'b0, 1'b1, 32'h0);
        step(); check_out("frozen_b", 1'b1, 1'b0, 1'b1, 32'h0);
        cfg.cfg_valid_i = 1'b1;
        cfg.cfg_inc_i   = 32'h2000_0000;
        step(); check_out("e_acc", 1'b1, 1'b0, 1'b0, 32'h0);
        cfg.cfg_valid_i = 1'b0;
        step(); check_out("e_apply", 1'b1, 1'b0, 1'b1, 32'h2000_0000);
        // Period 8 from acc = 0x8000_0000: three high, four low, then a tick.
        for (int k = 1; k <= 8; k++) begin
            step();
            check_out($sformatf("p8_%0d", k), (k <= 3) || (k == 8), (k == 8), 1'b1, 32'h2000_0000);
        end

        // Halt five cycles mid-high-phase; phase resumes exactly.
        step(); check_out("pre_halt", 1'b1, 1'b0, 1'b1, 32'h2000_0000);
        halt_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check_out($sformatf("halt_%0d", k), 1'b1, 1'b0, 1'b1, 32'h2000_0000);
            check($sformatf("halt_acc_%0d", k), dut.acc_r, 32'hA000_0000);
        end
        halt_i = 1'b0;
        step(); check_out("rel_a", 1'b1, 1'b0, 1'b1, 32'h2000_0000);
        step(); check_out("rel_b", 1'b1, 1'b0, 1'b1, 32'h2000_0000);
        step(); check_out("rel_c", 1'b0, 1'b0, 1'b1, 32'h2000_0000);
        step(); check_out("rel_d", 1'b0, 1'b0, 1'b1, 32'h2000_0000);
        step(); check_out("rel_e", 1'b0, 1'b0, 1'b1, 32'h2000_0000);
        step(); check_out("rel_f", 1'b0, 1'b0, 1'b1, 32'h2000_0000);
        step(); check_out("rel_g", 1'b1, 1'b1, 1'b1, 32'h2000_0000);

        // Disabled: pending value applies in one cycle.
        en_i            = 1'b0;
        cfg.cfg_valid_i = 1'b1;
        cfg.cfg_inc_i   = 32'h4000_0000;
        step(); check_out("dis_acc", 1'b1, 1'b0, 1'b0, 32'h2000_0000);
        cfg.cfg_valid_i = 1'b0;
        step(); check_out("dis_apply", 1'b1, 1'b0, 1'b1, 32'h4000_0000);

        // Halt holds a pending value until released.
        halt_i          = 1'b1;
        cfg.cfg_valid_i = 1'b1;
        cfg.cfg_inc_i   = 32'h1000_0000;
        step(); check_out("hp_acc", 1'b1, 1'b0, 1'b0, 32'h4000_0000);
        cfg.cfg_valid_i = 1'b0;
        step(); check_out("hp_hold_a", 1'b1, 1'b0, 1'b0, 32'h4000_0000);
        step(); check_out("hp_hold_b", 1'b1, 1'b0, 1'b0, 32'h4000_0000);
        halt_i = 1'b0;
        step(); check_out("hp_apply", 1'b1, 1'b0, 1'b1, 32'h1000_0000);

        // Reset while pending discards the shadow.
        en_i            = 1'b1;
        cfg.cfg_valid_i = 1'b1;
        cfg.cfg_inc_i   = 32'h2000_0000;
        step(); check_out("rp_acc", 1'b1, 1'b0, 1'b0, 32'h1000_0000);
        cfg.cfg_valid_i = 1'b0;
        areset          = 1'b1;
        step(); check_out("rp_reset", 1'b0, 1'b0, 1'b1, 32'h8000_0000);
        areset = 1'b0;
        en_i   = 1'b0;
        step(); check_out("rp_idle", 1'b0, 1'b0, 1'b1, 32'h8000_0000);
        en_i = 1'b1;
        step(); check_out("rp_run_a", 1'b1, 1'b1, 1'b1, 32'h8000_0000);
        step(); check_out("rp_run_b", 1'b0, 1'b0, 1'b1, 32'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
